sel_mux_pipe: RTL and testbench

Parametrised, registered N:1 word selector for the pipelined datapath, successor to the fixed 5:1 16-bit combinational mux. It adds a one-deep valid/ready output register, explicit out-of-range select reporting, and a round-robin mode that scans a mask of enabled inputs. It sits between operand/forwarding sources and the next pipeline stage, so the selected word is held while that stage stalls.

---
 rtl/sel_mux_pkg.sv | 18 +
 rtl/rr_pick.sv | 38 +++
 rtl/sel_mux_pipe.sv | 102 ++++++++++
 tb/tb_sel_mux_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_mux_pkg.sv
// Shared constants and helpers for the registered N:1 word selector.
package sel_mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_N     = 5;

  // Ceiling log2; used to size the select/index fields.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set mask bit at or after ptr, wrapping at N.
module rr_pick
  import sel_mux_pkg::*;
#(
  parameter  int unsigned N    = DEF_N,
  localparam int unsigned SELW = clog2(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            none
);

  localparam logic [SELW:0] N_EXT = N[SELW:0];

  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;

  // Rotate so the pointer position lands at bit 0.
  assign dbl = {mask, mask};
  assign rot = N'(dbl >> ptr);

  // Lowest set bit of the rotated mask wins.
  always_comb begin
    off = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
  end

  // Undo the rotation modulo N.
  assign sum  = {1'b0, ptr} + {1'b0, off};
  assign idx  = (sum >= N_EXT) ? SELW'(sum - N_EXT) : SELW'(sum);
  assign none = ~|mask;

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered N:1 word selector with valid/ready output stage and round-robin mode.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned N     = DEF_N,
  localparam int unsigned SELW  = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  input  logic [N-1:0]       mask,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   m,
  output logic [SELW-1:0]    m_idx,
  output logic               sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [SELW:0]   N_EXT = N[SELW:0];
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_idx;
  logic             rr_none;
  logic [WIDTH-1:0] dir_word;
  logic [WIDTH-1:0] rr_word;
  logic [WIDTH-1:0] nxt_m;
  logic [SELW-1:0]  nxt_idx;
  logic             nxt_err;
  logic [SELW-1:0]  nxt_ptr;
  logic             accept;

  rr_pick #(.N(N)) u_rr_pick (
    .mask (mask),
    .ptr  (rr_ptr),
    .idx  (rr_idx),
    .none (rr_none)
  );

  // Single-entry output stage: free when empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Word muxes for the direct select and the round-robin pick.
  always_comb begin
    dir_word = '0;
    rr_word  = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel == SELW'(k))    dir_word = d[k*WIDTH +: WIDTH];
      if (rr_idx == SELW'(k)) rr_word  = d[k*WIDTH +: WIDTH];
    end
  end

  // Value captured on accept, plus the pointer advance for round-robin.
  always_comb begin
    nxt_m   = '0;
    nxt_idx = sel;
    nxt_err = 1'b0;
    nxt_ptr = rr_ptr;
    case (mode)
      MODE_DIRECT: begin
        if ({1'b0, sel} < N_EXT) nxt_m = dir_word;
        else                     nxt_err = 1'b1;
      end
      default: begin
        if (rr_none) begin
          nxt_idx = rr_ptr;
          nxt_err = 1'b1;
        end else begin
          nxt_m   = rr_word;
          nxt_idx = rr_idx;
          nxt_ptr = (rr_idx == LAST) ? '0 : rr_idx + 1'b1;
        end
      end
    endcase
  end

  // Output register; payload is held through stalls and after a plain drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      m         <= '0;
      m_idx     <= '0;
      sel_err   <= 1'b0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (accept) begin
      m         <= nxt_m;
      m_idx     <= nxt_idx;
      sel_err   <= nxt_err;
      out_valid <= 1'b1;
      rr_ptr    <= nxt_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic vs a reference model.
module tb_sel_mux_pipe;

  logic clk;

  // N=5, WIDTH=16 instance
  logic        rst0, iv0, ir0, mode0, er0, ov0, or0;
  logic [79:0] d0;
  logic [2:0]  sel0, mi0;
  logic [4:0]  mask0;
  logic [15:0] m0;

  // N=8, WIDTH=32 instance
  logic         rst1, iv1, ir1, mode1, er1, ov1, or1;
  logic [255:0] d1;
  logic [2:0]   sel1, mi1;
  logic [7:0]   mask1;
  logic [31:0]  m1;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 0;

  // Reference state
  bit          e0v, e0e, e1v, e1e;
  logic [15:0] e0m;
  logic [31:0] e1m;
  int          e0i, e0p, e1i, e1p;
  logic [35:0] q1[$];

  localparam logic [79:0] DBASE = {16'd4097, 16'd2059, 16'd1024, 16'd974, 16'd400};
  int lit1_m[6]   = '{400, 974, 1024, 2059, 4097, 0};
  int lit4_idx[5] = '{1, 2, 4, 1, 2};
  int lit4_m[5]   = '{974, 1024, 4097, 974, 1024};

  sel_mux_pipe u0 (
    .clk(clk), .rst(rst0), .d(d0), .sel(sel0), .mode(mode0), .mask(mask0),
    .in_valid(iv0), .in_ready(ir0), .m(m0), .m_idx(mi0), .sel_err(er0),
    .out_valid(ov0), .out_ready(or0)
  );

  sel_mux_pipe #(.WIDTH(32), .N(8)) u1 (
    .clk(clk), .rst(rst1), .d(d1), .sel(sel1), .mode(mode1), .mask(mask1),
    .in_valid(iv1), .in_ready(ir1), .m(m1), .m_idx(mi1), .sel_err(er1),
    .out_valid(ov1), .out_ready(or1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Selection rule: direct index, or first enabled input scanning from ptr with wrap.
  task automatic ref_pick(input int n, input int md, input int s, input int msk, input int ptr,
                          output int idx, output bit err, output int nptr);
    idx = s; err = 0; nptr = ptr;
    if (md == 0) begin
      err = (s >= n);
    end else begin
      err = 1; idx = ptr;
      for (int j = 0; j < n; j++) begin
        int k;
        k = (ptr + j) % n;
        if (err && msk[k]) begin
          err = 0; idx = k; nptr = (k + 1) % n;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    int idx, np;
    bit err;
    if (rst0) begin
      e0v = 0; e0m = '0; e0i = 0; e0e = 0; e0p = 0;
    end else if (iv0 && (!e0v || or0)) begin
      ref_pick(5, int'(mode0), int'(sel0), int'(mask0), e0p, idx, err, np);
      e0v = 1; e0i = idx; e0e = err; e0p = np;
      e0m = err ? 16'd0 : d0[idx*16 +: 16];
    end else if (or0) begin
      e0v = 0;
    end
    if (rst1) begin
      e1v = 0; e1m = '0; e1i = 0; e1e = 0; e1p = 0;
      q1.delete();
    end else if (iv1 && (!e1v || or1)) begin
      ref_pick(8, int'(mode1), int'(sel1), int'(mask1), e1p, idx, err, np);
      e1v = 1; e1i = idx; e1e = err; e1p = np;
      e1m = err ? 32'd0 : d1[idx*32 +: 32];
      q1.push_back({e1m, 3'(idx), err});
    end else if (or1) begin
      e1v = 0;
    end
  end

  // Per-cycle comparison against the model, plus in-order scoreboard on the wide instance.
  always @(negedge clk) begin
    logic [35:0] exp;
    if (chk_en) begin
      chk("u0.out_valid", 64'(ov0), 64'(e0v));
      chk("u0.in_ready", 64'(ir0), 64'(!e0v || or0));
      chk("u0.m", 64'(m0), 64'(e0m));
      chk("u0.m_idx", 64'(mi0), 64'(e0i));
      chk("u0.sel_err", 64'(er0), 64'(e0e));
      chk("u1.out_valid", 64'(ov1), 64'(e1v));
      chk("u1.in_ready", 64'(ir1), 64'(!e1v || or1));
      chk("u1.m", 64'(m1), 64'(e1m));
      chk("u1.m_idx", 64'(mi1), 64'(e1i));
      chk("u1.sel_err", 64'(er1), 64'(e1e));
      if (ov1 && or1 && !rst1) begin
        if (q1.size() == 0) begin
          tot_cnt++;
          $display("FAIL sb_underflow: got drain of m=%0h with no pending accept at %0t", m1, $time);
        end else begin
          exp = q1.pop_front();
          chk("sb.word", 64'({m1, mi1, er1}), 64'(exp));
        end
      end
    end
  end

  initial begin
    clk = 0;
    rst0 = 1; rst1 = 1; iv0 = 0; iv1 = 0; or0 = 1; or1 = 1;
    sel0 = '0; sel1 = '0; mode0 = 0; mode1 = 0; mask0 = '0; mask1 = '0;
    d0 = DBASE;
    for (int i = 0; i < 8; i++) d1[i*32 +: 32] = $urandom;
    step();
    chk("rst.in_ready", 64'(ir0), 64'd1);
    step();
    rst0 = 0; rst1 = 0; chk_en = 1;
    chk("rst.out_valid", 64'(ov0), 64'd0);
    chk("rst.m", 64'(m0), 64'd0);
    chk("rst.m_idx", 64'(mi0), 64'd0);
    chk("rst.sel_err", 64'(er0), 64'd0);

    // Direct sweep including the out-of-range select
    mode0 = 0; iv0 = 1;
    for (int s = 0; s < 6; s++) begin
      sel0 = 3'(s);
      step();
      chk("sweep.m", 64'(m0), 64'(lit1_m[s]));
      chk("sweep.m_idx", 64'(mi0), 64'(s));
      chk("sweep.sel_err", 64'(er0), 64'(s == 5));
    end

    // Advance rr_ptr, load 2059, then reset with a concurrent request
    mode0 = 1; mask0 = 5'b11111;
    step();
    chk("pre.rr_idx", 64'(mi0), 64'd0);
    mode0 = 0; sel0 = 3'd3;
    step();
    chk("pre.m", 64'(m0), 64'd2059);
    rst0 = 1;
    step();
    rst0 = 0;
    chk("rst2.out_valid", 64'(ov0), 64'd0);
    chk("rst2.m", 64'(m0), 64'd0);
    chk("rst2.m_idx", 64'(mi0), 64'd0);
    chk("rst2.sel_err", 64'(er0), 64'd0);
    chk("rst2.in_ready", 64'(ir0), 64'd1);
    mode0 = 1; mask0 = 5'b11111;
    step();
    chk("rst2.rr_ptr_zero", 64'(mi0), 64'd0);
    chk("rst2.rr_m", 64'(m0), 64'd400);

    // Round-robin wrap over 10110 (pointer now 1)
    mask0 = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr.m_idx", 64'(mi0), 64'(lit4_idx[i]));
      chk("rr.m", 64'(m0), 64'(lit4_m[i]));
    end

    // Stall: held word ignores sel and d changes
    mode0 = 0; sel0 = 3'd2;
    step();
    chk("stall.first", 64'(m0), 64'd1024);
    or0 = 0; sel0 = 3'd4; d0[2*16 +: 16] = 16'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.m", 64'(m0), 64'd1024);
      chk("stall.in_ready", 64'(ir0), 64'd0);
    end
    or0 = 1;
    #1;
    chk("stall.release_ready", 64'(ir0), 64'd1);
    step();
    chk("stall.next_m", 64'(m0), 64'd4097);
    d0 = DBASE;

    // Empty mask, mode switch, resume at preserved pointer (3)
    mode0 = 1; mask0 = 5'b00000;
    step();
    chk("empty.m", 64'(m0), 64'd0);
    chk("empty.sel_err", 64'(er0), 64'd1);
    chk("empty.m_idx", 64'(mi0), 64'd3);
    mode0 = 0; sel0 = 3'd3;
    step();
    chk("switch.m", 64'(m0), 64'd2059);
    mode0 = 1; mask0 = 5'b11111;
    step();
    chk("resume.m_idx", 64'(mi0), 64'd3);
    chk("resume.m", 64'(m0), 64'd2059);
    iv0 = 0;
    step();
    chk("drain.out_valid", 64'(ov0), 64'd0);
    chk("drain.m_held", 64'(m0), 64'd2059);

    // Random traffic on both instances
    for (int c = 0; c < 2000; c++) begin
      rst0  = ($urandom_range(0, 99) == 0);
      iv0   = ($urandom_range(0, 3) != 0);
      or0   = ($urandom_range(0, 4) > 1);
      mode0 = 1'($urandom_range(0, 1));
      sel0  = 3'($urandom_range(0, 7));
      mask0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      d0    = 80'({$urandom, $urandom, $urandom});
      iv1   = ($urandom_range(0, 3) != 0);
      or1   = ($urandom_range(0, 4) > 1);
      mode1 = 1'($urandom_range(0, 1));
      sel1  = 3'($urandom_range(0, 7));
      mask1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      for (int i = 0; i < 8; i++) d1[i*32 +: 32] = $urandom;
      step();
    end
    rst0 = 0; iv0 = 0; iv1 = 0; or0 = 1; or1 = 1;
    repeat (3) step();
    chk("sb.pending_left", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
